rgb_hue_sequencer: RTL
======================

Name: rgb_hue_sequencer

Overview:
- Drives the three `pwm` instances' duty values (`pwm_value_r/g/b`) so the RGB LED cycles continuously around the colour wheel.
- Runs a six-sector hue state machine. In each sector exactly one channel ramps up or down while the other two hold.
- Replaces the fixed/unused per-channel `pwm_value` registers in the top level, and supersedes the single-channel fade block.

Parameters:
- PWM_INTERVAL, 1200, PWM period in clk cycles (must match the `pwm` instances). FULL = PWM_INTERVAL-1. Value width W = $clog2(PWM_INTERVAL).
- STEP_CYCLES, 120000, enabled clk cycles between duty updates (10 ms at 12 MHz). Must be ≥2.
- INC_DEC_VAL, 12, duty change per update. Must satisfy 1 ≤ INC_DEC_VAL ≤ FULL.

Ports:
- clk, input, 1, system clock (12 MHz).
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, 1 = sequencing runs; 0 = freeze all state.
- pwm_value_r, output, W, red duty value to `pwm`.
- pwm_value_g, output, W, green duty value to `pwm`.
- pwm_value_b, output, W, blue duty value to `pwm`.
- sector, output, 3, current hue sector, 0..5.
- step_pulse, output, 1, one-cycle pulse on each duty update.
- wrap_pulse, output, 1, one-cycle pulse when sector advances 5→0.

Behaviour:
- Single clock domain; all outputs registered. rst is sampled on the clk rising edge only and overrides enable.
- Reset values:
  - sector = 0, pwm_value_r = FULL, pwm_value_g = 0, pwm_value_b = 0.
  - Tick counter = 0; step_pulse = 0; wrap_pulse = 0.
- Tick counter (width $clog2(STEP_CYCLES)):
  - Increments on each clk edge where enable = 1.
  - When counter == STEP_CYCLES-1 on an enabled edge: it wraps to 0 and that same edge performs a duty update.
  - The first update after reset occurs on the STEP_CYCLES-th enabled edge.
- enable = 0: counter, sector and all pwm_value_* hold; step_pulse = wrap_pulse = 0. Re-asserting enable resumes from the held count; there is no restart.
- Sector table (ramping channel / direction; the other two channels hold):
  - S0: G up (R = FULL, B = 0).
  - S1: R down (G = FULL, B = 0).
  - S2: B up (G = FULL, R = 0).
  - S3: G down (B = FULL, R = 0).
  - S4: R up (B = FULL, G = 0).
  - S5: B down (R = FULL, G = 0).
- Update arithmetic (compute in W+1 bits; no overflow or underflow permitted):
  - Up: if v + INC_DEC_VAL ≥ FULL, then v ← FULL and sector advances on the same edge. Otherwise v ← v + INC_DEC_VAL.
  - Down: if v ≤ INC_DEC_VAL, then v ← 0 and sector advances on the same edge. Otherwise v ← v − INC_DEC_VAL.
  - Sector advance is s ← s+1; from 5 it goes to 0.
- Pulse timing:
  - step_pulse = 1 for exactly the cycle following each update edge (registered together with the new values).
  - wrap_pulse is asserted in that same cycle only when the update moved sector 5→0.
- Invariants, checkable on every cycle:
  - Exactly one channel is non-constant per sector.
  - Every value is ≤ FULL.
  - sector never takes values 6 or 7. If it does (illegal state), the next edge forces the reset state.
- Reset mid-ramp: the next edge restores the full reset state regardless of enable; the partial count is discarded.
- Ticks per sector = ceil(FULL / INC_DEC_VAL). Full hue cycle = 6 × that × STEP_CYCLES enabled cycles.
- Top level inverts pwm_out for the active-low LED; this block is polarity-agnostic.

Test Plan (PWM_INTERVAL=16 → FULL=15, STEP_CYCLES=4, INC_DEC_VAL=4):
- Reset: hold rst for 3 edges with enable=1 → R=15, G=0, B=0, sector=0, pulses 0. No change occurs while rst=1.
- Sector 0 ramp: release rst, enable=1 → G=4,8,12,15 after enabled edges 4,8,12,16. sector becomes 1 on edge 16. step_pulse high exactly one cycle after each update; R and B stay constant.
- Full cycle:
  - Run 96 enabled edges → sector sequence 0,1,2,3,4,5,0.
  - Values at the S1 end: R=0, G=15, B=0.
  - wrap_pulse asserts exactly once, after edge 96; values are back to R=15, G=0, B=0.
- Down clamp: in S1 starting from R=15 → R=11,7,3,0. It never goes negative or wraps to a large value, and the sector advances on the 0 update.
- Freeze: deassert enable for 10 cycles at counter=2 mid-S0 → all outputs and pulses hold. After re-enable the next update comes 2 enabled edges later, not 4.
- Reset mid-operation: assert rst for 1 edge in S3 with counter=3 and enable=1 → the reset state appears, with no step_pulse. The first update then comes on the 4th enabled edge after release.

Source files
------------

// File: rtl/rgb_hue_sequencer.sv
// Six-sector colour-wheel sequencer: ramps one PWM duty value per sector while the
// other two hold, stepping every STEP_CYCLES enabled clocks.
module rgb_hue_sequencer #(
  parameter int PWM_INTERVAL = 1200,
  parameter int STEP_CYCLES  = 120000,
  parameter int INC_DEC_VAL  = 12,
  localparam int W           = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  output logic [W-1:0] pwm_value_r,
  output logic [W-1:0] pwm_value_g,
  output logic [W-1:0] pwm_value_b,
  output logic [2:0]   sector,
  output logic         step_pulse,
  output logic         wrap_pulse
);

  // state | meaning
  // S0    | G ramps up   (R = FULL, B = 0)
  // S1    | R ramps down (G = FULL, B = 0)
  // S2    | B ramps up   (G = FULL, R = 0)
  // S3    | G ramps down (B = FULL, R = 0)
  // S4    | R ramps up   (B = FULL, G = 0)
  // S5    | B ramps down (R = FULL, G = 0)
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2,
                            S3 = 3'd3, S4 = 3'd4, S5 = 3'd5} sector_t;

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [W-1:0]  FULL_W  = W'(PWM_INTERVAL - 1);
  localparam logic [W:0]    FULL_W1 = (W+1)'(PWM_INTERVAL - 1);
  localparam logic [W-1:0]  INC_W   = W'(INC_DEC_VAL);
  localparam logic [W:0]    INC_W1  = (W+1)'(INC_DEC_VAL);
  localparam logic [CW-1:0] CNT_TC  = CW'(STEP_CYCLES - 1);

  sector_t       state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [W-1:0]  r_n, g_n, b_n;
  logic          step_n, wrap_n;
  logic          illegal;

  logic [1:0]    ramp_ch;
  logic          ramp_up;
  logic [W-1:0]  ramp_val, new_val;
  logic [W:0]    up_sum;
  logic          done;
  sector_t       sector_adv;

  assign illegal = (state == 3'd6) || (state == 3'd7);

  always_comb begin
    ramp_ch    = 2'd1;
    ramp_up    = 1'b1;
    sector_adv = S0;
    case (state)
      S0: begin ramp_ch = 2'd1; ramp_up = 1'b1; sector_adv = S1; end
      S1: begin ramp_ch = 2'd0; ramp_up = 1'b0; sector_adv = S2; end
      S2: begin ramp_ch = 2'd2; ramp_up = 1'b1; sector_adv = S3; end
      S3: begin ramp_ch = 2'd1; ramp_up = 1'b0; sector_adv = S4; end
      S4: begin ramp_ch = 2'd0; ramp_up = 1'b1; sector_adv = S5; end
      S5: begin ramp_ch = 2'd2; ramp_up = 1'b0; sector_adv = S0; end
      default: begin ramp_ch = 2'd1; ramp_up = 1'b1; sector_adv = S0; end
    endcase
  end

  // Up path saturates at FULL using a W+1 bit sum; down path clamps at 0 before subtracting.
  always_comb begin
    case (ramp_ch)
      2'd0:    ramp_val = pwm_value_r;
      2'd1:    ramp_val = pwm_value_g;
      default: ramp_val = pwm_value_b;
    endcase
    up_sum  = {1'b0, ramp_val} + INC_W1;
    new_val = ramp_val;
    done    = 1'b0;
    if (ramp_up) begin
      if (up_sum >= FULL_W1) begin
        new_val = FULL_W;
        done    = 1'b1;
      end else begin
        new_val = up_sum[W-1:0];
      end
    end else begin
      if ({1'b0, ramp_val} <= INC_W1) begin
        new_val = '0;
        done    = 1'b1;
      end else begin
        new_val = ramp_val - INC_W;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_n     = pwm_value_r;
    g_n     = pwm_value_g;
    b_n     = pwm_value_b;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
    if (enable) begin
      if (cnt == CNT_TC) begin
        cnt_n  = '0;
        step_n = 1'b1;
        case (ramp_ch)
          2'd0:    r_n = new_val;
          2'd1:    g_n = new_val;
          default: b_n = new_val;
        endcase
        if (done) begin
          state_n = sector_adv;
          wrap_n  = (state == S5);
        end
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || illegal) begin
      state       <= S0;
      cnt         <= '0;
      pwm_value_r <= FULL_W;
      pwm_value_g <= '0;
      pwm_value_b <= '0;
      step_pulse  <= 1'b0;
      wrap_pulse  <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pwm_value_r <= r_n;
      pwm_value_g <= g_n;
      pwm_value_b <= b_n;
      step_pulse  <= step_n;
      wrap_pulse  <= wrap_n;
    end
  end

  assign sector = state;

endmodule
